axi_mem_responder: RTL
======================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ID_W, default 3, AXI ID width (matches LSU bus tag width).
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of 64-bit storage words (power of two).
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_l  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port axi_awvalid  in  1  write address valid.
REQ-006 SHALL have port axi_awready  out  1  write address accepted.
REQ-007 SHALL have port axi_awid  in  ID_W  write transaction ID.
REQ-008 SHALL have port axi_awaddr  in  32  write byte address.
REQ-009 SHALL have port axi_awlen  in  8  write beats minus one.
REQ-010 SHALL have port axi_awburst  in  2  write burst type.
REQ-011 SHALL have port axi_wvalid  in  1  write data valid.
REQ-012 SHALL have port axi_wready  out  1  write data accepted.
REQ-013 SHALL have port axi_wdata  in  64  write data.
REQ-014 SHALL have port axi_wstrb  in  8  byte enables.
REQ-015 SHALL have port axi_bvalid  out  1  write response valid.
REQ-016 SHALL have port axi_bready  in  1  write response accepted.
REQ-017 SHALL have port axi_bid  out  ID_W  echoed awid.
REQ-018 SHALL have port axi_bresp  out  2  write response code.
REQ-019 SHALL have port axi_arvalid  in  1  read address valid.
REQ-020 SHALL have port axi_arready  out  1  read address accepted.
REQ-021 SHALL have port axi_arid  in  ID_W  read transaction ID.
REQ-022 SHALL have port axi_araddr  in  32  read byte address.
REQ-023 SHALL have port axi_arlen  in  8  read beats minus one.
REQ-024 SHALL have port axi_arburst  in  2  read burst type.
REQ-025 SHALL have port axi_rvalid  out  1  read data valid.
REQ-026 SHALL have port axi_rready  in  1  read data accepted.
REQ-027 SHALL have port axi_rid  out  ID_W  echoed arid.
REQ-028 SHALL have port axi_rdata  out  64  read data.
REQ-029 SHALL have port axi_rresp  out  2  read response code.
REQ-030 SHALL have port axi_rlast  out  1  final read beat.

Function
REQ-031 SHALL run FSM IDLE, WDATA, WRESP, RDATA; one transaction outstanding; awready/arready high only in IDLE, and only toward the granted channel.
REQ-032 SHALL arbitrate in IDLE: single requester wins; awvalid and arvalid together -> grant the channel not granted last (write after reset).
REQ-033 SHALL on AW handshake latch id/addr/len/burst, enter WDATA; wready=1 from the next cycle; each W handshake writes strobed bytes to mem[addr[31:3]]; after awlen+1 beats enter WRESP with bvalid=1 the following cycle.
REQ-034 SHALL hold bvalid/bid/bresp stable until bready; return to IDLE the cycle after the B handshake.
REQ-035 SHALL on AR handshake enter RDATA with rvalid=1 the next cycle; beats back-to-back while rready=1; rdata/rid/rresp/rlast stable while rready=0; rlast=1 only on beat arlen+1; IDLE after the last handshake.
REQ-036 SHALL increment address by 8 per beat for INCR (2'b01), 32-bit wrap-around; hold address for FIXED (2'b00).
REQ-037 SHALL treat WRAP (2'b10) and reserved (2'b11) as SLVERR (2'b10): W beats consumed without writing, R beats return zero data, full beat count honoured.
REQ-038 SHALL give DECERR (2'b11) to any beat whose addr[31:3] >= MEM_WORDS: no write, rdata zero; bresp = worst code of all beats (DECERR > SLVERR > OKAY).
REQ-039 SHALL ignore wvalid outside WDATA, and arvalid/awvalid outside IDLE.

Reset
REQ-040 SHALL drive all ready/valid outputs, bid, bresp, rid, rdata, rresp, rlast to 0 and FSM to IDLE under reset, including mid-burst (burst abandoned); memory contents SHALL NOT be reset.

Structure
REQ-041 SHALL take response codes (OKAY/SLVERR/DECERR) and burst codes from shared package swervolf_axi_pkg, alongside the FSM state typedef.
REQ-042 SHALL use one sub-module, axi_burst_addr, computing next beat address, beat count and per-beat error code; storage inline.

Verification
REQ-043 SHALL cover single write awaddr=0x10, wdata=0x1122334455667788, wstrb=0x0F, then read 0x10 -> rdata low 32 bits 0x55667788, bresp=rresp=0, rlast=1.
REQ-044 SHALL cover INCR read arlen=3 at 0x0 with rready toggling every cycle -> 4 beats, data stable when stalled, rlast only on beat 4, rid echoed.
REQ-045 SHALL cover awvalid and arvalid asserted together twice -> write granted first, read second.
REQ-046 SHALL cover write to byte address 8*MEM_WORDS, awlen=1 -> 2 W beats accepted, bresp=2'b11, memory unchanged.
REQ-047 SHALL cover WRAP read arlen=1 -> 2 beats, rresp=2'b10, rdata=0.
REQ-048 SHALL cover rst_l low during beat 2 of a 4-beat write -> next cycle all outputs 0, FSM IDLE, new AW accepted after release.

Source files
------------

// File: rtl/swervolf_axi_pkg.sv
// Shared AXI codes and responder FSM state for the SweRVolf memory-side blocks.
package swervolf_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_e;

    // Response codes are ordered so that the numerically larger code is the more severe one.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Per-beat burst bookkeeping: next address, beat counter, last-beat flag and beat response code.
module axi_burst_addr
    import swervolf_axi_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic [31:0] addr,
    input  logic [1:0]  burst,
    input  logic [7:0]  cnt,
    input  logic [7:0]  len,
    output logic [31:0] next_addr,
    output logic [7:0]  next_cnt,
    output logic        last,
    output logic [1:0]  resp
);

    logic in_range;

    assign in_range  = {3'b000, addr[31:3]} < 32'(MEM_WORDS);
    assign next_addr = (burst == BURST_INCR) ? addr + 32'd8 : addr;
    assign next_cnt  = cnt + 8'd1;
    assign last      = (cnt == len);

    // An out-of-range beat reports DECERR even inside an unsupported burst.
    always_comb begin
        resp = RESP_OKAY;
        if (!in_range) begin
            resp = RESP_DECERR;
        end else if (burst[1]) begin
            resp = RESP_SLVERR;
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI4 memory slave with inline 64-bit storage, strobed writes and
// INCR/FIXED bursts; unsupported bursts and out-of-range beats return error codes.
module axi_mem_responder
    import swervolf_axi_pkg::*;
#(
    parameter int ID_W      = 3,
    parameter int MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [ID_W-1:0] axi_awid,
    input  logic [31:0]     axi_awaddr,
    input  logic [7:0]      axi_awlen,
    input  logic [1:0]      axi_awburst,
    input  logic            axi_wvalid,
    output logic            axi_wready,
    input  logic [63:0]     axi_wdata,
    input  logic [7:0]      axi_wstrb,
    output logic            axi_bvalid,
    input  logic            axi_bready,
    output logic [ID_W-1:0] axi_bid,
    output logic [1:0]      axi_bresp,
    input  logic            axi_arvalid,
    output logic            axi_arready,
    input  logic [ID_W-1:0] axi_arid,
    input  logic [31:0]     axi_araddr,
    input  logic [7:0]      axi_arlen,
    input  logic [1:0]      axi_arburst,
    output logic            axi_rvalid,
    input  logic            axi_rready,
    output logic [ID_W-1:0] axi_rid,
    output logic [63:0]     axi_rdata,
    output logic [1:0]      axi_rresp,
    output logic            axi_rlast
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_e          state_q, state_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            rvalid_q, rvalid_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1:0]      burst_q, burst_d;
    logic [1:0]      wacc_q, wacc_d;
    logic            prefer_rd_q, prefer_rd_d;

    logic [63:0]     mem_q [MEM_WORDS];

    logic            idle, grant_wr, grant_rd, w_hs, b_hs, r_hs, mem_we;
    logic [31:0]     cur_addr, next_addr;
    logic [1:0]      cur_burst, beat_resp;
    logic [7:0]      cur_cnt, cur_len, next_cnt;
    logic            beat_last;
    logic [IDX_W-1:0] cur_idx;
    logic [63:0]     beat_data;

    assign idle = (state_q == ST_IDLE);

    // On a tie the channel that lost last time wins; a write wins the first tie after reset.
    assign grant_wr = rst_l && idle && axi_awvalid && (!axi_arvalid || !prefer_rd_q);
    assign grant_rd = rst_l && idle && axi_arvalid && !grant_wr;

    assign w_hs = wready_q && axi_wvalid;
    assign b_hs = bvalid_q && axi_bready;
    assign r_hs = rvalid_q && axi_rready;

    // In IDLE the beat logic looks at the incoming AR so the first read beat is ready at once.
    assign cur_addr  = idle ? axi_araddr  : addr_q;
    assign cur_burst = idle ? axi_arburst : burst_q;
    assign cur_cnt   = idle ? 8'd0        : cnt_q;
    assign cur_len   = idle ? axi_arlen   : len_q;

    axi_burst_addr #(
        .MEM_WORDS (MEM_WORDS)
    ) u_burst_addr (
        .addr      (cur_addr),
        .burst     (cur_burst),
        .cnt       (cur_cnt),
        .len       (cur_len),
        .next_addr (next_addr),
        .next_cnt  (next_cnt),
        .last      (beat_last),
        .resp      (beat_resp)
    );

    assign cur_idx   = cur_addr[IDX_W+2:3];
    assign beat_data = (beat_resp == RESP_OKAY) ? mem_q[cur_idx] : 64'd0;
    assign mem_we    = (state_q == ST_WDATA) && w_hs && (beat_resp == RESP_OKAY);

    always_comb begin
        state_d     = state_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        wacc_d      = wacc_q;
        prefer_rd_d = prefer_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_d     = ST_WDATA;
                    wready_d    = 1'b1;
                    bid_d       = axi_awid;
                    addr_d      = axi_awaddr;
                    len_d       = axi_awlen;
                    burst_d     = axi_awburst;
                    cnt_d       = 8'd0;
                    wacc_d      = RESP_OKAY;
                    prefer_rd_d = 1'b1;
                end else if (grant_rd) begin
                    // addr_q/cnt_q track the beat after the one being presented.
                    state_d     = ST_RDATA;
                    rvalid_d    = 1'b1;
                    rid_d       = axi_arid;
                    rdata_d     = beat_data;
                    rresp_d     = beat_resp;
                    rlast_d     = beat_last;
                    addr_d      = next_addr;
                    cnt_d       = next_cnt;
                    len_d       = axi_arlen;
                    burst_d     = axi_arburst;
                    prefer_rd_d = 1'b0;
                end
            end
            ST_WDATA: begin
                if (w_hs) begin
                    addr_d = next_addr;
                    cnt_d  = next_cnt;
                    wacc_d = worst_resp(wacc_q, beat_resp);
                    if (beat_last) begin
                        state_d  = ST_WRESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = worst_resp(wacc_q, beat_resp);
                    end
                end
            end
            ST_WRESP: begin
                if (b_hs) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            ST_RDATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        rdata_d = beat_data;
                        rresp_d = beat_resp;
                        rlast_d = beat_last;
                        addr_d  = next_addr;
                        cnt_d   = next_cnt;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= 64'd0;
            rresp_q     <= RESP_OKAY;
            rlast_q     <= 1'b0;
            addr_q      <= 32'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            burst_q     <= BURST_FIXED;
            wacc_q      <= RESP_OKAY;
            prefer_rd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            wacc_q      <= wacc_d;
            prefer_rd_q <= prefer_rd_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (axi_wstrb[i]) begin
                    mem_q[cur_idx][8*i +: 8] <= axi_wdata[8*i +: 8];
                end
            end
        end
    end

    assign axi_awready = grant_wr;
    assign axi_arready = grant_rd;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rid     = rid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;

endmodule
